pipeline_hazard_ctrl: RTL and testbench

Central sequencing unit for the five-stage MIPS pipeline. It owns every PC and pipeline-register write-enable and flush in the datapath, and resolves four conditions:
- load-use stalls;
- taken-branch redirects from MEM;
- jump/jr/jal redirects from WB;
- multi-cycle data-memory waits (SAD accelerator accesses).

It also runs a post-reset boot sequence that scrubs the unreset pipeline registers, drives the EX-stage forwarding selects, and keeps saturating stall/flush counters for the display path.

---
 rtl/pipe_ctrl_pkg.sv | 61 ++++++
 rtl/forward_unit.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard control
//               unit and the forwarding unit.
//               - state_e : sequencing FSM states (BOOT, RUN, WAIT)
//               - FWD_*   : ALU operand select encodings
//               - ctrl_t  : bundle of PC / pipeline-register enables + flushes
//               - fwd_sel : forwarding select for one source operand
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  // Control patterns for each resolved condition.
  localparam ctrl_t CTRL_BOOT    = 9'b0_1111_1111;
  localparam ctrl_t CTRL_FREEZE  = 9'b0_0000_0000;
  localparam ctrl_t CTRL_JUMP    = 9'b1_1111_1111;
  localparam ctrl_t CTRL_BRANCH  = 9'b1_1111_1110;
  localparam ctrl_t CTRL_LOADUSE = 9'b0_0111_0100;
  localparam ctrl_t CTRL_NORMAL  = 9'b1_1111_0000;

  // The younger producer (MEM) wins; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd
  );
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_unit
// Description : Purely combinational operand-forwarding selects.
// Ports       : rs_i, rt_i           - consumer source registers
//               mem_reg_write_i      - producer valid in MEM
//               mem_write_reg_i      - producer destination in MEM
//               wb_reg_write_i       - producer valid in WB
//               wb_write_reg_i       - producer destination in WB
//               fwd_a_o, fwd_b_o     - operand selects (00 reg, 10 MEM, 01 WB)
// Revision    : 1.0 - initial release
// ============================================================================
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] mem_write_reg_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_write_reg_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_sel(rs_i, mem_reg_write_i, mem_write_reg_i,
                           wb_reg_write_i, wb_write_reg_i);
  assign fwd_b_o = fwd_sel(rt_i, mem_reg_write_i, mem_write_reg_i,
                           wb_reg_write_i, wb_write_reg_i);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central sequencing unit for the five-stage pipeline. Drives
//               all PC / pipeline-register write enables and flushes,
//               resolving load-use stalls, MEM branch redirects, WB jump
//               redirects and data-memory waits. Runs a post-reset scrub,
//               provides EX forwarding selects and saturating counters.
// Ports       : clk_i, rst_n_i        - clock, async active-low reset
//               id_*                  - ID-stage source registers and usage
//               ex_*                  - EX-stage load flag and rs/rt
//               mem_*/wb_*            - producer valid/destination
//               branch_taken_mem_i    - taken branch in MEM
//               jump_wb_i             - jump-class instruction in WB
//               dmem_wait_i           - data memory not ready
//               *_write_o, *_flush_o  - register enables / bubbles
//               fwd_a_o, fwd_b_o      - ALU operand selects
//               busy_o                - high during boot scrub
//               stall_cnt_o, flush_cnt_o - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [4:0]       ex_rs_i,
  input  logic             mem_reg_write_i,
  input  logic             wb_reg_write_i,
  input  logic [4:0]       mem_write_reg_i,
  input  logic [4:0]       wb_write_reg_i,
  input  logic             branch_taken_mem_i,
  input  logic             jump_wb_i,
  input  logic             dmem_wait_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  ctrl_t             ctrl;
  logic              stall_inc, flush_inc;
  logic              load_use;

  assign load_use = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((id_uses_rs_i && (id_rs_i == ex_rt_i)) ||
                     (id_uses_rt_i && (id_rt_i == ex_rt_i)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. RUN and WAIT share transitions: a freeze always lands
  // in WAIT, and leaving the freeze returns to RUN in the same cycle that the
  // pending redirect/stall is resolved.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 1'b1;
        end
      end
      ST_RUN, ST_WAIT: begin
        state_d = dmem_wait_i ? ST_WAIT : ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl      = CTRL_BOOT;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      ST_BOOT: ctrl = CTRL_BOOT;
      ST_RUN, ST_WAIT: begin
        if (dmem_wait_i) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (jump_wb_i) begin
          ctrl      = CTRL_JUMP;
          flush_inc = 1'b1;
        end else if (branch_taken_mem_i) begin
          ctrl      = CTRL_BRANCH;
          flush_inc = 1'b1;
        end else if (load_use) begin
          ctrl      = CTRL_LOADUSE;
          stall_inc = 1'b1;
        end else begin
          ctrl      = CTRL_NORMAL;
        end
      end
      default: ctrl = CTRL_BOOT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  forward_unit u_forward_unit (
    .rs_i            (ex_rs_i),
    .rt_i            (ex_rt_i),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_write_reg_i (mem_write_reg_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_write_reg_i  (wb_write_reg_i),
    .fwd_a_o         (fwd_a_o),
    .fwd_b_o         (fwd_b_o)
  );

  assign pc_write_o     = ctrl.pc_write;
  assign if_id_write_o  = ctrl.if_id_write;
  assign id_ex_write_o  = ctrl.id_ex_write;
  assign ex_mem_write_o = ctrl.ex_mem_write;
  assign mem_wb_write_o = ctrl.mem_wb_write;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_flush_o = ctrl.ex_mem_flush;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign busy_o         = (state_q == ST_BOOT);
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. A behavioural
//               reference model predicts every cycle's outputs; predictions
//               go through a scoreboard queue and are compared on the falling
//               clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int unsigned BOOT_CYCLES = 4;
  localparam int unsigned CNT_W       = 8;  // small so saturation is reachable

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       uses_rs, uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt, ex_rs;
    logic       mem_rw;
    logic [4:0] mem_wr;
    logic       wb_rw;
    logic [4:0] wb_wr;
    logic       br, jmp, dw;
  } in_t;

  typedef struct packed {
    logic [8:0]       ctrl;
    logic [1:0]       fa, fb;
    logic             busy;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt, ex_rs, mem_wr, wb_wr;
  logic uses_rs, uses_rt, ex_mem_read, mem_rw, wb_rw, br, jmp, dw;
  logic pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f;
  logic [1:0] fwd_a, fwd_b;
  logic busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int               m_state;  // 0 boot, 1 run, 2 wait
  int               m_boot;
  logic [CNT_W-1:0] m_stall, m_flush;
  exp_t             sb_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
    .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt), .ex_rs_i(ex_rs),
    .mem_reg_write_i(mem_rw), .wb_reg_write_i(wb_rw),
    .mem_write_reg_i(mem_wr), .wb_write_reg_i(wb_wr),
    .branch_taken_mem_i(br), .jump_wb_i(jmp), .dmem_wait_i(dw),
    .pc_write_o(pc_w), .if_id_write_o(ifid_w), .id_ex_write_o(idex_w),
    .ex_mem_write_o(exmem_w), .mem_wb_write_o(memwb_w),
    .if_id_flush_o(ifid_f), .id_ex_flush_o(idex_f),
    .ex_mem_flush_o(exmem_f), .mem_wb_flush_o(memwb_f),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .busy_o(busy),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic mw,
                                         input logic [4:0] mr, input logic ww,
                                         input logic [4:0] wr);
    if (mw && mr != 5'd0 && mr == src) return 2'b10;
    if (ww && wr != 5'd0 && wr == src) return 2'b01;
    return 2'b00;
  endfunction

  // Predicted outputs plus which counter should step at the next edge.
  task automatic predict(input in_t v, output exp_t e, output bit si, output bit fi);
    bit lu;
    lu = v.ex_mem_read && v.ex_rt != 5'd0 &&
         ((v.uses_rs && v.id_rs == v.ex_rt) || (v.uses_rt && v.id_rt == v.ex_rt));
    si = 1'b0;
    fi = 1'b0;
    e.fa   = ref_fwd(v.ex_rs, v.mem_rw, v.mem_wr, v.wb_rw, v.wb_wr);
    e.fb   = ref_fwd(v.ex_rt, v.mem_rw, v.mem_wr, v.wb_rw, v.wb_wr);
    e.busy = (m_state == 0);
    e.sc   = m_stall;
    e.fc   = m_flush;
    // bit order: pc, w ifid/idex/exmem/memwb, f ifid/idex/exmem/memwb
    if (m_state == 0)  e.ctrl = 9'b0_1111_1111;
    else if (v.dw)     begin e.ctrl = 9'b0_0000_0000; si = 1'b1; end
    else if (v.jmp)    begin e.ctrl = 9'b1_1111_1111; fi = 1'b1; end
    else if (v.br)     begin e.ctrl = 9'b1_1111_1110; fi = 1'b1; end
    else if (lu)       begin e.ctrl = 9'b0_0111_0100; si = 1'b1; end
    else               e.ctrl = 9'b1_1111_0000;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_boot  = BOOT_CYCLES - 1;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic apply(input in_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; uses_rs = v.uses_rs; uses_rt = v.uses_rt;
    ex_mem_read = v.ex_mem_read; ex_rt = v.ex_rt; ex_rs = v.ex_rs;
    mem_rw = v.mem_rw; mem_wr = v.mem_wr; wb_rw = v.wb_rw; wb_wr = v.wb_wr;
    br = v.br; jmp = v.jmp; dw = v.dw;
  endtask

  task automatic compare(input string tag);
    exp_t g;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    g = sb_q.pop_front();
    check({tag, "_ctrl"}, 32'({pc_w, ifid_w, idex_w, exmem_w, memwb_w,
                              ifid_f, idex_f, exmem_f, memwb_f}), 32'(g.ctrl));
    check({tag, "_fwd_a"}, 32'(fwd_a), 32'(g.fa));
    check({tag, "_fwd_b"}, 32'(fwd_b), 32'(g.fb));
    check({tag, "_busy"}, 32'(busy), 32'(g.busy));
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(g.sc));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(g.fc));
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance model.
  task automatic run_cycle(input string tag, input in_t v);
    exp_t e;
    bit si, fi;
    apply(v);
    predict(v, e, si, fi);
    sb_q.push_back(e);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else if (m_state == 0) begin
      if (m_boot == 0) m_state = 1;
      else m_boot--;
    end else begin
      if (si && m_stall != '1) m_stall++;
      if (fi && m_flush != '1) m_flush++;
      m_state = v.dw ? 2 : 1;
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t rnd();
    in_t v;
    v = '0;
    v.id_rs = 5'($urandom_range(0, 3));
    v.id_rt = 5'($urandom_range(0, 3));
    v.uses_rs = 1'($urandom_range(0, 1));
    v.uses_rt = 1'($urandom_range(0, 1));
    v.ex_mem_read = 1'($urandom_range(0, 1));
    v.ex_rt = 5'($urandom_range(0, 3));
    v.ex_rs = 5'($urandom_range(0, 3));
    v.mem_rw = 1'($urandom_range(0, 1));
    v.mem_wr = 5'($urandom_range(0, 3));
    v.wb_rw = 1'($urandom_range(0, 1));
    v.wb_wr = 5'($urandom_range(0, 3));
    v.br  = ($urandom_range(0, 5) == 0);
    v.jmp = ($urandom_range(0, 7) == 0);
    v.dw  = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  initial begin : main
    in_t  v;
    exp_t e;
    bit   si, fi;

    model_reset();
    apply(idle());

    // Reset held for 3 cycles, then 4 boot cycles and the first RUN cycle.
    for (int i = 0; i < 3; i++) run_cycle("rst_hold", idle());
    rst_n = 1'b1;
    for (int i = 0; i < BOOT_CYCLES; i++) run_cycle("boot", idle());
    run_cycle("first_run", idle());
    check("run_busy_low", 32'(busy), 32'd0);

    // Load-use: lw r8 in EX, add using r8 in ID -> single bubble.
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd8; v.id_rs = 5'd8; v.uses_rs = 1'b1;
    run_cycle("load_use", v);
    v = idle(); v.ex_rs = 5'd8; v.wb_rw = 1'b1; v.wb_wr = 5'd8;
    run_cycle("load_use_fwd", v);
    check("load_use_fwd_a_wb", 32'(fwd_a), 32'b01);
    check("load_use_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load on r0 or unused operand never stalls.
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd0; v.id_rs = 5'd0; v.uses_rs = 1'b1;
    run_cycle("load_r0", v);
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd9; v.id_rt = 5'd9; v.uses_rt = 1'b0;
    run_cycle("load_unused", v);
    v.uses_rt = 1'b1;
    run_cycle("load_use_rt", v);

    // Forwarding priority on both operands.
    v = idle(); v.mem_rw = 1'b1; v.mem_wr = 5'd5; v.wb_rw = 1'b1; v.wb_wr = 5'd5;
    v.ex_rs = 5'd5; v.ex_rt = 5'd5;
    run_cycle("fwd_mem_wins", v);
    v.mem_wr = 5'd0;
    run_cycle("fwd_wb", v);
    v.ex_rs = 5'd0; v.ex_rt = 5'd0;
    run_cycle("fwd_none", v);
    v = idle(); v.mem_rw = 1'b0; v.mem_wr = 5'd6; v.ex_rt = 5'd6;
    run_cycle("fwd_mem_invalid", v);

    // Branch alone, then branch together with jump.
    v = idle(); v.br = 1'b1;
    run_cycle("branch", v);
    v.jmp = 1'b1;
    run_cycle("branch_jump", v);
    v = idle(); v.jmp = 1'b1;
    run_cycle("jump", v);

    // Memory wait held 3 cycles with a pending branch; redirect on cycle 4.
    v = idle(); v.br = 1'b1; v.dw = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle("dmem_wait", v);
    v.dw = 1'b0;
    run_cycle("wait_exit_branch", v);
    run_cycle("after_wait", idle());

    // Leaving WAIT straight into a load-use stall.
    v = idle(); v.dw = 1'b1;
    run_cycle("wait2", v);
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd3; v.id_rs = 5'd3; v.uses_rs = 1'b1;
    run_cycle("wait_exit_loaduse", v);

    // Mixed traffic.
    for (int i = 0; i < 300; i++) run_cycle("random", rnd());

    // Saturation: a long freeze pins stall_cnt at all-ones.
    v = idle(); v.dw = 1'b1;
    for (int i = 0; i < 300; i++) run_cycle("saturate", v);
    check("stall_saturated", 32'(stall_cnt), 32'((1 << CNT_W) - 1));

    // Asynchronous reset in the middle of a WAIT cycle.
    apply(v);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    predict(v, e, si, fi);
    sb_q.push_back(e);
    compare("async_rst");
    apply(idle());
    @(posedge clk);
    #1;
    run_cycle("rst_hold2", idle());
    rst_n = 1'b1;
    for (int i = 0; i < BOOT_CYCLES; i++) run_cycle("boot2", idle());
    run_cycle("run2", idle());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
